// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: back end of the FP add/sub datapath. Normalizes the raw
// adder significand, rounds to nearest-even and packs an IEEE-754 single.
// Build option: define FP_NORM_LZC_EN to replace the one-bit-per-cycle
// normalizer with a leading-zero-count shifter (fixed 4-cycle latency,
// bit-identical results).
module fp_norm_round_pack #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [FRAC_W+4:0]       sig_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    inexact
);

  // significand layout: [SIG_W-1] carry, [SIG_W-2] hidden, fraction, G, R, S
  localparam int unsigned SIG_W   = FRAC_W + 5;
  localparam int unsigned EXP_IW  = EXP_W + 2;
  localparam int unsigned RES_W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
  localparam int unsigned B_CARRY = SIG_W - 1;
  localparam int unsigned B_HID   = SIG_W - 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  // Internal exponent: exp_in zero-extended; stays within 0..EXP_MAX+1.
  logic [EXP_IW-1:0]  exp_q, exp_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               inexact_q, inexact_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  // Rounding datapath: round-to-nearest-even increment at the LSB (bit 3).
  logic               rnd_lsb, rnd_g, rnd_r, rnd_s;
  logic               rnd_up;
  logic [SIG_W-1:0]   rnd_sum;

  assign rnd_lsb = sig_q[3];
  assign rnd_g   = sig_q[2];
  assign rnd_r   = sig_q[1];
  assign rnd_s   = sig_q[0];
  assign rnd_up  = rnd_g & (rnd_lsb | rnd_r | rnd_s);
  assign rnd_sum = sig_q + (rnd_up ? SIG_W'(8) : SIG_W'(0));

`ifdef FP_NORM_LZC_EN
  localparam int unsigned LZ_W = $clog2(SIG_W);

  logic               pre_q, pre_d;
  logic [LZ_W-1:0]    lzc;
  logic [LZ_W-1:0]    lzc_sh;

  // Leading zeros above the carry bit; highest set bit wins.
  function automatic logic [LZ_W-1:0] count_lz(input logic [SIG_W-2:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(SIG_W - 1);
    for (int i = 0; i < int'(SIG_W) - 1; i++) begin
      if (v[i]) n = LZ_W'(int'(SIG_W) - 2 - i);
    end
    return n;
  endfunction

  // Shift distance limited so the exponent never drops below 1.
  always_comb begin
    lzc = count_lz(sig_q[SIG_W-2:0]);
    if (EXP_IW'(lzc) < exp_q) lzc_sh = lzc;
    else                      lzc_sh = LZ_W'(exp_q - EXP_IW'(1));
  end
`endif

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef FP_NORM_LZC_EN
    pre_d       = pre_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = sign_in;
          exp_d      = EXP_IW'(exp_in);
          sig_d      = sig_in;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_NORM;
`ifdef FP_NORM_LZC_EN
          pre_d      = 1'b1;
`endif
        end
      end

      S_NORM: begin
`ifdef FP_NORM_LZC_EN
        // First NORM cycle: one-shot left shift, then classify next cycle.
        if (pre_q) begin
          pre_d = 1'b0;
          if ((sig_q != '0) && !sig_q[B_CARRY] && !sig_q[B_HID] &&
              (exp_q > EXP_IW'(1))) begin
            sig_d = sig_q << lzc_sh;
            exp_d = exp_q - EXP_IW'(lzc_sh);
          end
        end else
`endif
        if (sig_q == '0) begin
          exp_d   = '0;
`ifdef FP_NORM_LZC_EN
          state_d = S_ROUND;
`else
          state_d = S_PACK;
`endif
        end else if (sig_q[B_CARRY]) begin
          // Right shift keeps the dropped bit in sticky.
          sig_d   = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
          exp_d   = exp_q + EXP_IW'(1);
          state_d = S_ROUND;
        end else if (sig_q[B_HID]) begin
          state_d = S_ROUND;
        end else if (exp_q <= EXP_IW'(1)) begin
          // Subnormal: exponent field 0, significand left as is.
          exp_d   = '0;
          state_d = S_ROUND;
        end else begin
          sig_d   = {sig_q[SIG_W-2:0], 1'b0};
          exp_d   = exp_q - EXP_IW'(1);
        end
      end

      S_ROUND: begin
        inexact_d = rnd_g | rnd_r | rnd_s;
        if (rnd_sum[B_CARRY]) begin
          sig_d = {1'b0, rnd_sum[SIG_W-1:1]};
          exp_d = exp_q + EXP_IW'(1);
        end else begin
          sig_d = rnd_sum;
          if ((exp_q == '0) && rnd_sum[B_HID]) exp_d = EXP_IW'(1);
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        if (exp_q >= EXP_IW'(EXP_MAX)) begin
          result_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          overflow_d = 1'b1;
        end else begin
          result_d   = {sign_q, exp_q[EXP_W-1:0], sig_q[FRAC_W+2:3]};
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef FP_NORM_LZC_EN
      pre_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef FP_NORM_LZC_EN
      pre_q       <= pre_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// tb_fp_norm_round_pack: directed vectors, handshake/reset sequences and
// random operands checked against an arithmetic reference model.
module tb_fp_norm_round_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] sig_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  fp_norm_round_pack #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .sig_in    (sig_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        sgn;
    logic [7:0]  e;
    logic [27:0] s;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Latency in the LZC build is fixed.
  function automatic int lat_adj(input int l);
`ifdef FP_NORM_LZC_EN
    return 4;
`else
    return l;
`endif
  endfunction

  // Reference: value-level normalize, RNE round and pack.
  function automatic void model(input logic sgn, input int e_in, input logic [27:0] s_in,
                                output logic [31:0] res, output logic ovf,
                                output logic inx, output int lat);
    longint m, keep, rem;
    int e, n, msb;
    e = e_in;
    m = longint'(s_in);
    ovf = 1'b0;
    inx = 1'b0;
    n = 0;
    if (m == 0) begin
      res = {sgn, 31'h0};
      lat = lat_adj(2);
      return;
    end
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e = e + 1;
    end else begin
      msb = 0;
      for (int i = 0; i < 27; i++) if (s_in[i]) msb = i;
      n = 26 - msb;
      if (n > e - 1) n = (e > 1) ? e - 1 : 0;
      m = m << n;
      e = e - n;
      if (m < (64'd1 << 26)) e = 0;
    end
    keep = m >> 3;
    rem  = m % 8;
    inx  = (rem != 0);
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
    if (keep >= (64'd1 << 24)) begin
      keep = keep >> 1;
      e = e + 1;
    end else if (e == 0 && keep >= (64'd1 << 23)) begin
      e = 1;
    end
    if (e >= 255) begin
      res = {sgn, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else begin
      res = {sgn, 8'(e), 23'(keep)};
    end
    lat = lat_adj(3 + n);
  endfunction

  // One full transaction: accept, wait for result, optional backpressure, drain.
  task automatic run_op(input string tag, input logic sgn, input logic [7:0] e,
                        input logic [27:0] s, input int hold,
                        input logic [31:0] xres, input logic xovf,
                        input logic xinx, input int xlat);
    int n;
    int cyc;
    @(negedge clk);
    sign_in  = sgn;
    exp_in   = e;
    sig_in   = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (!out_valid) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(xlat));
    chk({tag, " result"}, result, xres);
    chk({tag, " overflow"}, 32'(overflow), 32'(xovf));
    chk({tag, " inexact"}, 32'(inexact), 32'(xinx));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold result"}, result, xres);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drain out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " drain in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] mres;
    logic        movf;
    logic        minx;
    int          mlat;
    logic        rs;
    logic [7:0]  re;
    logic [27:0] rsig;

    vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 26};
    vecs[2]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 3};
    vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 3};
    vecs[4]  = '{1'b0, 8'd127, 28'h7FFFFFE, 32'h40000000, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3};
    vecs[6]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[7]  = '{1'b0, 8'd1,   28'h2000000, 32'h00400000, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 1'b0, 1'b1, 3};
    vecs[9]  = '{1'b0, 8'd3,   28'h0000008, 32'h00000004, 1'b0, 1'b0, 5};
    vecs[10] = '{1'b0, 8'd100, 28'h8000001, 32'h32800000, 1'b0, 1'b1, 3};
    vecs[11] = '{1'b1, 8'd127, 28'h800000C, 32'hC0000001, 1'b0, 1'b1, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    sig_in    = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset inexact", 32'(inexact), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].e, vecs[i].s, 0,
             vecs[i].res, vecs[i].ovf, vecs[i].inx, lat_adj(vecs[i].lat));
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    run_op("hold5", vecs[0].sgn, vecs[0].e, vecs[0].s, 5,
           vecs[0].res, vecs[0].ovf, vecs[0].inx, lat_adj(vecs[0].lat));

    // Asynchronous reset in the middle of a long normalization.
    @(negedge clk);
    sign_in  = 1'b0;
    exp_in   = 8'd127;
    sig_in   = 28'h0000008;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    chk("midnorm in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", vecs[2].sgn, vecs[2].e, vecs[2].s, 1,
           vecs[2].res, vecs[2].ovf, vecs[2].inx, lat_adj(vecs[2].lat));

    // Random operands against the reference model.
    for (int k = 0; k < 150; k++) begin
      rs   = 1'($urandom_range(0, 1));
      re   = 8'($urandom_range(0, 255));
      rsig = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) rsig = '0;
      model(rs, int'(re), rsig, mres, movf, minx, mlat);
      run_op($sformatf("rnd%0d", k), rs, re, rsig, $urandom_range(0, 2),
             mres, movf, minx, mlat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Back-end of the FP add/sub datapath, the inverse of the significand-prep stage.
- Takes the raw 28-bit adder significand: carry bit, hidden bit, 23-bit fraction, and guard/round/sticky bits.
- Normalizes it with an iterative shifter FSM and rounds round-to-nearest-even.
- Strips the hidden bit and packs an IEEE-754 single. Valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, biased exponent width.
- FRAC_W, 23, stored fraction width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept; high only in IDLE.
- sign_in  input  1  result sign.
- exp_in  input  EXP_W  biased exponent of the larger operand.
- sig_in  input  FRAC_W+5  bits: [27] carry, [26] hidden, [25:3] fraction, [2:0] G,R,S.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- result  output  32  packed {sign, exponent, fraction}.
- overflow  output  1  result rounded to infinity.
- inexact  output  1  any of G/R/S nonzero after normalization.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, inexact=0.
- Internal exponent is 10-bit signed (exp_in zero-extended); significand register is 28 bits.

State IDLE:
- On in_valid&&in_ready, latch sign_in/exp_in/sig_in and go to NORM.

State NORM, one action per cycle:
- sig==0: result is signed zero {sign,0,0}; go to PACK.
- sig[27]==1: shift right 1, sticky = old bit0 | shifted-out bit; exp+1; go to ROUND.
- sig[26]==1: go to ROUND.
- exp<=1: denormal; keep sig; exp=0 marks a subnormal; go to ROUND.
- Otherwise: shift left 1, zero fill, exp-1; stay in NORM.

State ROUND:
- lsb=sig[3], g=sig[2], r=sig[1], s=sig[0].
- inexact=g|r|s.
- Round up iff g&(lsb|r|s); adds 1 at bit 3.
- If the add carries into bit 27: shift right 1, exp+1.
- If a subnormal carries into bit 26: exp becomes 1.
- Go to PACK.

State PACK:
- exp>=255: result={sign,8'hFF,0}, overflow=1.
- Otherwise: result={sign,exp[7:0],sig[25:3]}.
- out_valid=1; go to OUT.

State OUT:
- Hold result/flags/out_valid stable until out_ready; then out_valid=0 and go to IDLE.
- in_ready returns next cycle; no bypass.

Latency and throughput:
- Latency from accept to out_valid = 3 + number of left shifts (max 26 left shifts).
- One operation in flight.
- No NaN/infinity input handling; upstream special-case logic bypasses this block.

Optional Feature:
- Macro: FP_NORM_LZC_EN.
- Defined: NORM uses a leading-zero counter over sig[26:0] and performs a single-cycle left shift by min(lzc, exp-1); exp is reduced by the same amount.
- Defined: latency is fixed at 4 cycles for every input.
- Undefined: iterative one-bit-per-cycle shifting as specified above.
- Results and flags are bit-identical in both builds.

Test Plan:
1. Carry normalize: sign 0, exp 127, sig {1,0,23'h0,3'b000} (1.0+1.0) -> result 32'h40000000, overflow 0, inexact 0, latency 3.
2. Massive cancellation: exp 127, sig 28'h0000008 -> 23 NORM shifts, result 32'h34000000, out_valid at cycle 26 after accept.
3. Ties to even:
   - exp 127, sig {0,1,23'h000001,3'b100} -> 32'h3F800002, inexact 1.
   - Same with fraction 23'h0 -> 32'h3F800000, inexact 1.
4. Rounding carry-out and overflow:
   - exp 127, sig {0,1,23'h7FFFFF,3'b110} -> 32'h40000000.
   - exp 254, sig {1,0,23'h0,3'b000} -> 32'h7F800000, overflow 1.
5. Zero and subnormal:
   - sign 1, sig 0 -> 32'h80000000.
   - exp 1, sig {0,0,23'h400000,3'b000} -> 32'h00400000.
6. Handshake and reset:
   - out_ready low 5 cycles -> result/out_valid stable and in_ready 0 throughout.
   - rst pulse mid-NORM -> out_valid 0 and in_ready 1 immediately.
   - Next operation is processed correctly.
